// File: rtl/pwm_pkg.sv
// Shared types and helpers for the multi-channel PWM generator.
// The shadow-register option of pwm_multi_gen is selected with the PWM_SHADOW_EN macro.
package pwm_pkg;

    localparam int NCH_MAX = 8;

    typedef enum logic [2:0] {
        OP_NONE,
        OP_INC1,
        OP_INC0,
        OP_DEC1,
        OP_DEC0
    } btn_op_e;

    // Highest-priority press wins: inc1 > inc0 > dec1 > dec0.
    function automatic btn_op_e pick_op(input logic p_inc1, input logic p_inc0,
                                        input logic p_dec1, input logic p_dec0);
        if (p_inc1) return OP_INC1;
        if (p_inc0) return OP_INC0;
        if (p_dec1) return OP_DEC1;
        if (p_dec0) return OP_DEC0;
        return OP_NONE;
    endfunction

    function automatic int unsigned sat_add(input int unsigned a, input int unsigned b,
                                            input int unsigned lim);
        int unsigned s;
        s = a + b;
        return (s > lim) ? lim : s;
    endfunction

    function automatic int unsigned sat_sub(input int unsigned a, input int unsigned b);
        return (b > a) ? 0 : a - b;
    endfunction

endpackage

// File: rtl/pwm_btn_edge.sv
// Active-low pushbutton conditioner: 2-flop synchroniser, previous-value flop and
// falling-edge detector producing a single-cycle press pulse.
module pwm_btn_edge
    import pwm_pkg::*;
(
    input  logic clkin,
    input  logic reset,
    input  logic btn,
    output logic press
);

    logic sync_p0, sync_p1, prev_p2;
    logic seen, armed;

    // armed only rises once a genuine released sample follows reset, so a button
    // held down across reset cannot fake a press against the reset value of 1.
    always_ff @(posedge clkin) begin
        if (reset) begin
            sync_p0 <= 1'b1;
            sync_p1 <= 1'b1;
            prev_p2 <= 1'b1;
            seen    <= 1'b0;
            armed   <= 1'b0;
        end else begin
            sync_p0 <= btn;
            sync_p1 <= sync_p0;
            prev_p2 <= sync_p1;
            seen    <= 1'b1;
            armed   <= armed | (seen & sync_p0);
        end
    end

    assign press = armed & prev_p2 & ~sync_p1;

endmodule

// File: rtl/pwm_multi_gen.sv
// Multi-channel PWM generator: shared period counter, per-channel duty registers
// adjusted by four pushbuttons. Optional macro PWM_SHADOW_EN adds period-aligned duty shadowing.
module pwm_multi_gen
    import pwm_pkg::*;
#(
    parameter int CW          = 8,
    parameter int NCH         = 2,
    parameter int PERIOD      = 100,
    parameter int DUTY_INIT   = 50,
    parameter int FINE_STEP   = 1,
    parameter int COARSE_STEP = 10
) (
    input  logic                                  clkin,
    input  logic                                  reset,
    input  logic                                  inc0,
    input  logic                                  inc1,
    input  logic                                  dec0,
    input  logic                                  dec1,
    input  logic [((NCH > 1) ? $clog2(NCH) : 1)-1:0] sel,
    output logic [NCH-1:0]                        pwm,
    output logic [CW-1:0]                         duty_o,
    output logic                                  tick
);

    localparam int NCH_LIM = (NCH < NCH_MAX) ? NCH : NCH_MAX;
    localparam logic [CW-1:0] CNT_LAST = CW'(PERIOD - 1);
    localparam logic [CW-1:0] DUTY_RST = CW'(DUTY_INIT);

    logic [CW-1:0] cnt, cnt_nxt;
    logic [CW-1:0] target [NCH];
    logic [CW-1:0] active [NCH];
    logic          p_inc0, p_inc1, p_dec0, p_dec1;
    logic          sel_ok;
    btn_op_e       op;
    logic [CW-1:0] cur, upd;

    pwm_btn_edge u_inc1 (.clkin(clkin), .reset(reset), .btn(inc1), .press(p_inc1));
    pwm_btn_edge u_inc0 (.clkin(clkin), .reset(reset), .btn(inc0), .press(p_inc0));
    pwm_btn_edge u_dec1 (.clkin(clkin), .reset(reset), .btn(dec1), .press(p_dec1));
    pwm_btn_edge u_dec0 (.clkin(clkin), .reset(reset), .btn(dec0), .press(p_dec0));

    always_comb cnt_nxt = (cnt == CNT_LAST) ? '0 : cnt + 1'b1;

    always_ff @(posedge clkin) begin
        if (reset) begin
            cnt  <= '0;
            tick <= 1'b0;
        end else begin
            cnt  <= cnt_nxt;
            tick <= (cnt_nxt == CNT_LAST);
        end
    end

    // Out-of-range sel leaves cur at 0, which is also what duty_o must show.
    always_comb begin
        cur = '0;
        for (int i = 0; i < NCH; i++) begin
            if (int'(sel) == i) cur = target[i];
        end
        sel_ok = int'(sel) < NCH_LIM;
        op     = pick_op(p_inc1, p_inc0, p_dec1, p_dec0);
        case (op)
            OP_INC1: upd = CW'(sat_add(32'(cur), COARSE_STEP, PERIOD));
            OP_INC0: upd = CW'(sat_add(32'(cur), FINE_STEP, PERIOD));
            OP_DEC1: upd = CW'(sat_sub(32'(cur), COARSE_STEP));
            OP_DEC0: upd = CW'(sat_sub(32'(cur), FINE_STEP));
            default: upd = cur;
        endcase
    end

    assign duty_o = cur;

    always_ff @(posedge clkin) begin
        if (reset) begin
            for (int i = 0; i < NCH; i++) target[i] <= DUTY_RST;
        end else if (sel_ok && op != OP_NONE) begin
            for (int i = 0; i < NCH; i++) begin
                if (int'(sel) == i) target[i] <= upd;
            end
        end
    end

`ifdef PWM_SHADOW_EN
    always_ff @(posedge clkin) begin
        if (reset) begin
            for (int i = 0; i < NCH; i++) active[i] <= DUTY_RST;
        end else if (cnt == CNT_LAST) begin
            for (int i = 0; i < NCH; i++) active[i] <= target[i];
        end
    end
`else
    always_comb begin
        for (int i = 0; i < NCH; i++) active[i] = target[i];
    end
`endif

    always_ff @(posedge clkin) begin
        if (reset) begin
            pwm <= '0;
        end else begin
            for (int i = 0; i < NCH; i++) pwm[i] <= (cnt < active[i]);
        end
    end

endmodule

// File: tb/tb_pwm_multi_gen.sv
// Self-checking bench for pwm_multi_gen against an edge-level behavioural model
// (honours PWM_SHADOW_EN when defined for the build).
module tb_pwm_multi_gen;

    localparam int CW = 8, NCH = 3, PERIOD = 100, DUTY_INIT = 50, FINE = 1, COARSE = 10;

    logic           clk = 1'b0;
    logic           reset = 1'b1;
    logic           inc0 = 1'b1, inc1 = 1'b1, dec0 = 1'b1, dec1 = 1'b1;
    logic [1:0]     sel = 2'd0;
    logic [NCH-1:0] pwm;
    logic [CW-1:0]  duty_o;
    logic           tick;

    int n_cmp = 0, n_bad = 0;

    always #5 clk = ~clk;

    pwm_multi_gen #(.CW(CW), .NCH(NCH), .PERIOD(PERIOD), .DUTY_INIT(DUTY_INIT),
                    .FINE_STEP(FINE), .COARSE_STEP(COARSE)) dut (
        .clkin(clk), .reset(reset), .inc0(inc0), .inc1(inc1), .dec0(dec0), .dec1(dec1),
        .sel(sel), .pwm(pwm), .duty_o(duty_o), .tick(tick)
    );

    // Reference model: edge counter, duty per channel, and a list of pending presses.
    // A press is a released->pressed change of the level seen at an edge; it lands two edges later.
    typedef struct {int due; int btn;} press_t;
    press_t         pend[$];
    int             ecount = 0;
    int             mcnt = 0;
    int             mtarget[NCH] = '{default: DUTY_INIT};
    int             mactive[NCH] = '{default: DUTY_INIT};
    logic [NCH-1:0] mpwm = '0;
    logic           mtick = 1'b0;
    logic [3:0]     last_hi = 4'b0;

    always @(posedge clk) begin : model
        logic [3:0] lvl, hit;
        press_t     keep[$];
        int         t;
        ecount++;
        lvl = {inc1, inc0, dec1, dec0};
        if (reset) begin
            mcnt = 0; mtick = 1'b0; mpwm = '0; last_hi = 4'b0; pend.delete();
            for (int i = 0; i < NCH; i++) begin mtarget[i] = DUTY_INIT; mactive[i] = DUTY_INIT; end
        end else begin
            for (int i = 0; i < NCH; i++) begin
`ifdef PWM_SHADOW_EN
                mpwm[i] = (mcnt < mactive[i]);
`else
                mpwm[i] = (mcnt < mtarget[i]);
`endif
            end
`ifdef PWM_SHADOW_EN
            if (mcnt == PERIOD - 1) for (int i = 0; i < NCH; i++) mactive[i] = mtarget[i];
`endif
            hit = 4'b0; keep = {};
            foreach (pend[j]) begin
                if (pend[j].due == ecount) hit[pend[j].btn] = 1'b1;
                else keep.push_back(pend[j]);
            end
            pend = keep;
            if (hit != 4'b0 && int'(sel) < NCH) begin
                t = mtarget[sel];
                if (hit[3])      t = (t + COARSE > PERIOD) ? PERIOD : t + COARSE;
                else if (hit[2]) t = (t + FINE > PERIOD) ? PERIOD : t + FINE;
                else if (hit[1]) t = (t < COARSE) ? 0 : t - COARSE;
                else             t = (t < FINE) ? 0 : t - FINE;
                mtarget[sel] = t;
            end
            for (int b = 0; b < 4; b++) begin
                if (!lvl[b] && last_hi[b]) pend.push_back('{due: ecount + 2, btn: b});
                last_hi[b] = lvl[b];
            end
            mcnt  = (mcnt + 1) % PERIOD;
            mtick = (mcnt == PERIOD - 1);
        end
    end

    function automatic int exp_duty();
        if (int'(sel) < NCH) return mtarget[sel];
        return 0;
    endfunction

    // mask bits: {inc1, inc0, dec1, dec0}
    task automatic press(input logic [3:0] mask, input int hold);
        @(negedge clk);
        {inc1, inc0, dec1, dec0} = ~mask;
        repeat (hold) @(negedge clk);
        {inc1, inc0, dec1, dec0} = 4'hF;
        repeat (4) @(negedge clk);
    endtask

    task automatic reset_pulse();
        @(negedge clk); reset = 1'b1;
        @(negedge clk); reset = 1'b0;
        repeat (5) @(negedge clk);
    endtask

    task automatic test_reset();
        int hi;
        reset = 1'b1;
        repeat (3) begin
            @(negedge clk);
            n_cmp++;
            if (pwm !== '0) begin n_bad++; $display("FAIL reset_pwm: got %b want 000", pwm); end
            n_cmp++;
            if (duty_o !== 8'd50) begin n_bad++; $display("FAIL reset_duty: got %0d want 50", duty_o); end
        end
        reset = 1'b0;
        hi = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            hi += pwm[0] ? 1 : 0;
            n_cmp++;
            if (pwm !== mpwm || tick !== mtick) begin
                n_bad++; $display("FAIL reset_run: pwm %b tick %b want pwm %b tick %b", pwm, tick, mpwm, mtick);
            end
        end
        n_cmp++;
        if (hi != 50) begin n_bad++; $display("FAIL reset_highs: got %0d want 50", hi); end
    endtask

    task automatic test_steps();
        int         exp_v[4] = '{60, 70, 71, 72};
        logic [3:0] msk[4] = '{4'h8, 4'h8, 4'h4, 4'h4};
        sel = 2'd0;
        for (int j = 0; j < 4; j++) begin
            press(msk[j], $urandom_range(1, 4));
            n_cmp++;
            if (duty_o !== 8'(exp_v[j])) begin n_bad++; $display("FAIL steps_duty%0d: got %0d want %0d", j, duty_o, exp_v[j]); end
            n_cmp++;
            if (int'(duty_o) != exp_duty()) begin n_bad++; $display("FAIL steps_model%0d: got %0d want %0d", j, duty_o, exp_duty()); end
        end
        sel = 2'd1;
        @(negedge clk);
        n_cmp++;
        if (duty_o !== 8'd50) begin n_bad++; $display("FAIL steps_ch1: got %0d want 50", duty_o); end
    endtask

    task automatic test_saturation();
        int hi;
        sel = 2'd1;
        repeat (4) press(4'h8, 1);
        repeat (5) press(4'h4, 2);
        n_cmp++;
        if (duty_o !== 8'd95) begin n_bad++; $display("FAIL sat_95: got %0d want 95", duty_o); end
        press(4'h8, 1);
        n_cmp++;
        if (duty_o !== 8'd100) begin n_bad++; $display("FAIL sat_100: got %0d want 100", duty_o); end
        for (int pass = 0; pass < 2; pass++) begin
            if (pass == 1) begin
                repeat (11) press(4'h2, 1);
                n_cmp++;
                if (duty_o !== 8'd0) begin n_bad++; $display("FAIL sat_0: got %0d want 0", duty_o); end
            end
            hi = 0;
            for (int i = 0; i < 210; i++) begin
                @(negedge clk);
                if (i >= 110) hi += pwm[1] ? 1 : 0;
                n_cmp++;
                if (pwm !== mpwm) begin n_bad++; $display("FAIL sat_pwm: got %b want %b", pwm, mpwm); end
            end
            n_cmp++;
            if (hi != ((pass == 0) ? 100 : 0)) begin
                n_bad++; $display("FAIL sat_highs%0d: got %0d want %0d", pass, hi, (pass == 0) ? 100 : 0);
            end
        end
    endtask

    task automatic test_simultaneous();
        int want[3] = '{60, 50, 50};
        reset_pulse();
        sel = 2'd0;
        press(4'b1001, 2);
        n_cmp++;
        if (duty_o !== 8'd60) begin n_bad++; $display("FAIL simul: got %0d want 60", duty_o); end
        sel = 2'd3;
        press(4'($urandom_range(1, 15)), 2);
        n_cmp++;
        if (duty_o !== 8'd0) begin n_bad++; $display("FAIL badsel_duty: got %0d want 0", duty_o); end
        for (int s = 0; s < 3; s++) begin
            sel = 2'(s);
            @(negedge clk);
            n_cmp++;
            if (duty_o !== 8'(want[s])) begin n_bad++; $display("FAIL badsel_ch%0d: got %0d want %0d", s, duty_o, want[s]); end
        end
    endtask

    task automatic test_period_update();
        int ha, hb, guard, want_a;
        reset_pulse();
        sel = 2'd0;
        guard = 0;
        do begin @(negedge clk); guard++; end while (mcnt != 0 && guard < 300);
        n_cmp++;
        if (mcnt != 0) begin n_bad++; $display("FAIL period_sync: got %0d want 0", mcnt); end
        ha = 0; hb = 0;
        for (int i = 1; i <= 200; i++) begin
            @(negedge clk);
            if (i <= 100) ha += pwm[0] ? 1 : 0;
            else hb += pwm[0] ? 1 : 0;
            n_cmp++;
            if (pwm !== mpwm || tick !== mtick) begin
                n_bad++; $display("FAIL period_pwm: pwm %b tick %b want %b %b", pwm, tick, mpwm, mtick);
            end
            if (i == 18) inc1 = 1'b0;
            if (i == 20) inc1 = 1'b1;
        end
`ifdef PWM_SHADOW_EN
        want_a = 50;
`else
        want_a = 60;
`endif
        n_cmp++;
        if (ha != want_a) begin n_bad++; $display("FAIL period_a: got %0d want %0d", ha, want_a); end
        n_cmp++;
        if (hb != 60) begin n_bad++; $display("FAIL period_b: got %0d want 60", hb); end
    endtask

    task automatic test_reset_midop();
        int guard;
        reset_pulse();
        sel = 2'd0;
        press(4'h8, 1); press(4'h8, 1); press(4'h4, 1); press(4'h4, 1);
        n_cmp++;
        if (duty_o !== 8'd72) begin n_bad++; $display("FAIL mid_72: got %0d want 72", duty_o); end
        guard = 0;
        while (mcnt != 37 && guard < 300) begin @(negedge clk); guard++; end
        reset = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (pwm !== '0 || tick !== 1'b0) begin n_bad++; $display("FAIL mid_pwm: pwm %b tick %b want 000 0", pwm, tick); end
        n_cmp++;
        if (duty_o !== 8'd50) begin n_bad++; $display("FAIL mid_duty: got %0d want 50", duty_o); end
        inc1 = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            n_cmp++;
            if (duty_o !== 8'd50 || pwm !== mpwm) begin
                n_bad++; $display("FAIL held_run: duty %0d pwm %b want 50 %b", duty_o, pwm, mpwm);
            end
        end
        inc1 = 1'b1;
        repeat (5) @(negedge clk);
        n_cmp++;
        if (duty_o !== 8'd50) begin n_bad++; $display("FAIL held_release: got %0d want 50", duty_o); end
        press(4'h8, 1);
        n_cmp++;
        if (duty_o !== 8'd60) begin n_bad++; $display("FAIL held_after: got %0d want 60", duty_o); end
    endtask

    task automatic test_random();
        logic [3:0] m;
        int hold, gap;
        bit chg;
        for (int it = 0; it < 60; it++) begin
            m    = 4'($urandom_range(1, 15));
            hold = $urandom_range(1, 4);
            gap  = $urandom_range(3, 6);
            chg  = ($urandom_range(0, 3) == 0);
            sel  = 2'($urandom_range(0, 3));
            {inc1, inc0, dec1, dec0} = ~m;
            for (int c = 1; c <= hold + gap; c++) begin
                @(negedge clk);
                n_cmp++;
                if (pwm !== mpwm || tick !== mtick || int'(duty_o) != exp_duty()) begin
                    n_bad++;
                    $display("FAIL random%0d: pwm %b tick %b duty %0d want %b %b %0d",
                             it, pwm, tick, duty_o, mpwm, mtick, exp_duty());
                end
                if (c == hold) {inc1, inc0, dec1, dec0} = 4'hF;
                if (chg && c == 2) sel = 2'($urandom_range(0, 3));
            end
        end
    endtask

    initial begin
        test_reset();
        repeat (4) @(negedge clk);
        test_steps();
        test_saturation();
        test_simultaneous();
        test_period_update();
        test_reset_midop();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
